// File: rtl/icache_sa.sv
// Set-associative instruction cache with zero-latency lookup, critical-word-first AXI wrap
// fills, per-set round-robin replacement (invalid ways first), whole-cache flush and error pulse.
module icache_sa #(
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 128,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] sm_pc,
  output logic [31:0]           ir,
  output logic                  icache_valid,
  input  logic                  flush,
  output logic                  icache_err,
  output logic [ID_WIDTH-1:0]   icache_m_axi_arid,
  output logic [ADDR_WIDTH-1:0] icache_m_axi_araddr,
  output logic [7:0]            icache_m_axi_arlen,
  output logic [2:0]            icache_m_axi_arsize,
  output logic [1:0]            icache_m_axi_arburst,
  output logic                  icache_m_axi_arlock,
  output logic [3:0]            icache_m_axi_arcache,
  output logic [2:0]            icache_m_axi_arprot,
  output logic                  icache_m_axi_arvalid,
  input  logic                  icache_m_axi_arready,
  input  logic [ID_WIDTH-1:0]   icache_m_axi_rid,
  input  logic [DATA_WIDTH-1:0] icache_m_axi_rdata,
  input  logic [1:0]            icache_m_axi_rresp,
  input  logic                  icache_m_axi_rlast,
  input  logic                  icache_m_axi_rvalid,
  output logic                  icache_m_axi_rready
);

  localparam int unsigned OffW  = $clog2(LINE_WORDS);
  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned WayW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned LineW = ADDR_WIDTH - 3;
  localparam int unsigned TagW  = LineW - OffW - IdxW;

  typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

  state_e state_q, state_d;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [WayW-1:0]       rr_q    [SETS];
  logic [TagW-1:0]       tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][LINE_WORDS];

  logic [LineW-1:0] miss_q;
  logic [WayW-1:0]  victim_q;
  logic             victim_rr_q;
  logic [OffW-1:0]  fill_off_q;
  logic             err_seen_q;
  logic             flush_seen_q;
  logic             err_q;

  logic [OffW-1:0]       pc_off;
  logic [IdxW-1:0]       pc_idx;
  logic [TagW-1:0]       pc_tag;
  logic [IdxW-1:0]       fill_idx;
  logic [WAYS-1:0]       hit_vec;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [WayW-1:0]       victim;
  logic                  victim_rr;
  logic                  start_fill;
  logic                  beat;
  logic                  line_done;
  logic                  line_ok;
  logic                  err_final;

  assign pc_off   = sm_pc[3 +: OffW];
  assign pc_idx   = sm_pc[3 + OffW +: IdxW];
  assign pc_tag   = sm_pc[ADDR_WIDTH-1 -: TagW];
  assign fill_idx = miss_q[OffW +: IdxW];

  always_comb begin
    hit_vec  = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[pc_idx][w] && (tag_q[pc_idx][w] == pc_tag)) begin
        hit_vec[w] = 1'b1;
        hit_word   = data_q[pc_idx][w][pc_off];
      end
    end
  end

  assign icache_valid = |hit_vec;
  assign ir           = sm_pc[2] ? hit_word[63:32] : hit_word[31:0];

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    victim    = rr_q[pc_idx];
    victim_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[pc_idx][w]) begin
        victim    = WayW'(w);
        victim_rr = 1'b0;
      end
    end
  end

  assign err_final = err_seen_q | icache_m_axi_rresp[1];

  always_comb begin
    state_d              = state_q;
    start_fill           = 1'b0;
    beat                 = 1'b0;
    line_done            = 1'b0;
    line_ok              = 1'b0;
    icache_m_axi_arvalid = 1'b0;
    icache_m_axi_rready  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!icache_valid && !flush) begin
          start_fill = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        icache_m_axi_arvalid = 1'b1;
        if (icache_m_axi_arready) state_d = StFill;
      end
      StFill: begin
        icache_m_axi_rready = 1'b1;
        if (icache_m_axi_rvalid) begin
          beat = 1'b1;
          if (icache_m_axi_rlast) begin
            line_done = 1'b1;
            line_ok   = !err_final && !flush_seen_q && !flush;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      miss_q       <= '0;
      victim_q     <= '0;
      victim_rr_q  <= 1'b0;
      fill_off_q   <= '0;
      err_seen_q   <= 1'b0;
      flush_seen_q <= 1'b0;
      err_q        <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= line_done && err_final;
      if (state_q == StIdle) miss_q <= sm_pc[ADDR_WIDTH-1:3];
      if (start_fill) begin
        victim_q     <= victim;
        victim_rr_q  <= victim_rr;
        fill_off_q   <= pc_off;
        err_seen_q   <= 1'b0;
        flush_seen_q <= 1'b0;
      end
      if (beat) begin
        fill_off_q <= fill_off_q + OffW'(1);
        err_seen_q <= err_final;
      end
      // A flush during an outstanding fill must keep that fill's line invalid.
      if (flush && (state_q != StIdle)) flush_seen_q <= 1'b1;
      if (flush) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (start_fill) begin
        valid_q[pc_idx][victim] <= 1'b0;
      end else if (line_ok) begin
        valid_q[fill_idx][victim_q] <= 1'b1;
        if (victim_rr_q && (WAYS > 1)) rr_q[fill_idx] <= rr_q[fill_idx] + WayW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_fill) tag_q[pc_idx][victim] <= pc_tag;
    if (beat) data_q[fill_idx][victim_q][fill_off_q] <= icache_m_axi_rdata;
  end

  assign icache_err           = err_q;
  assign icache_m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign icache_m_axi_araddr  = {miss_q, 3'b000};
  assign icache_m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign icache_m_axi_arsize  = 3'd3;
  assign icache_m_axi_arburst = 2'd2;
  assign icache_m_axi_arlock  = 1'b0;
  assign icache_m_axi_arcache = 4'd0;
  assign icache_m_axi_arprot  = 3'd6;

  logic unused_inputs;
  assign unused_inputs = ^{icache_m_axi_rid, icache_m_axi_rresp[0], sm_pc[1:0]};

  hit_onehot_a: assert property (@(posedge clk) disable iff (!reset) $onehot0(hit_vec));

endmodule
